// File: rtl/if_stage_if.sv
// -----------------------------------------------------------------------------
// if_stage_if
// Instruction-memory request/response bundle between the fetch stage and the
// instruction memory.
//
// Signals:
//   imem_req    fetch stage -> memory : request valid
//   imem_addr   fetch stage -> memory : word-aligned fetch address
//   imem_ready  memory -> fetch stage : request accepted this cycle
//   imem_rvalid memory -> fetch stage : read data valid (one per accept)
//   imem_rdata  memory -> fetch stage : instruction word
//
// Modports:
//   master  used by the fetch stage
//   slave   used by the memory model
// -----------------------------------------------------------------------------
interface if_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rvalid,
    output imem_rdata
  );
endinterface

// File: rtl/if_stage.sv
// -----------------------------------------------------------------------------
// if_stage
// Instruction fetch stage. Issues one request at a time to instruction memory,
// registers the returned word into ir/pc for the decode stage, and uses a
// one-entry skid register when decode is stalled as the data arrives.
// A redirect flushes ir and restarts fetch at redirect_pc; a response still in
// flight at that moment is discarded.
//
// Parameters:
//   RESET_PC     first fetch address after reset
//   NOP_IR       value presented on ir whenever valid is low
//
// Ports:
//   clk          clock, all state updates on the rising edge
//   rst_n        asynchronous active-low reset
//   imem         instruction-memory bundle (master side)
//   stall        decode cannot take an instruction this cycle
//   redirect     flush and restart fetch at redirect_pc
//   redirect_pc  restart address, bits [1:0] ignored
//   ir           registered instruction to decode
//   pc           registered address of ir
//   valid        ir/pc hold a real instruction
// -----------------------------------------------------------------------------
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_IR   = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  if_stage_if.master  imem,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] ir,
  output logic [31:0] pc,
  output logic        valid
);

  typedef enum logic [1:0] {
    FETCH,
    WAIT,
    HOLD,
    DROP
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] pc_q, pc_d;
  logic        valid_q, valid_d;
  logic [31:0] skid_ir_q, skid_ir_d;
  logic [31:0] skid_pc_q, skid_pc_d;

  logic        accept;
  logic        slot_free;

  // The request is gated by rst_n so that it is low while reset is held,
  // even though the state register already sits in FETCH.
  assign imem.imem_req  = rst_n && (state_q == FETCH);
  assign imem.imem_addr = fetch_pc_q;

  assign accept    = (state_q == FETCH) && imem.imem_ready;
  assign slot_free = !valid_q || !stall;

  assign ir    = ir_q;
  assign pc    = pc_q;
  assign valid = valid_q;

  // Next-state logic. Redirect overrides everything; otherwise a consumed
  // instruction empties the output slot unless a new word fills it in the
  // same cycle. The skid register is occupied exactly while in HOLD.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    ir_d       = ir_q;
    pc_d       = pc_q;
    valid_d    = valid_q;
    skid_ir_d  = skid_ir_q;
    skid_pc_d  = skid_pc_q;

    if (redirect) begin
      valid_d    = 1'b0;
      ir_d       = NOP_IR;
      skid_ir_d  = NOP_IR;
      skid_pc_d  = 32'h0;
      fetch_pc_d = redirect_pc & 32'hFFFF_FFFC;
      unique case (state_q)
        FETCH:   state_d = accept ? DROP : FETCH;
        WAIT:    state_d = imem.imem_rvalid ? FETCH : DROP;
        HOLD:    state_d = FETCH;
        // A response landing together with a new redirect completes the
        // outstanding request, so nothing is left to drop.
        DROP:    state_d = imem.imem_rvalid ? FETCH : DROP;
        default: state_d = FETCH;
      endcase
    end else begin
      if (valid_q && !stall) begin
        valid_d = 1'b0;
        ir_d    = NOP_IR;
      end
      unique case (state_q)
        FETCH: begin
          if (accept) state_d = WAIT;
        end
        WAIT: begin
          if (imem.imem_rvalid) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
            if (slot_free) begin
              ir_d    = imem.imem_rdata;
              pc_d    = fetch_pc_q;
              valid_d = 1'b1;
              state_d = FETCH;
            end else begin
              skid_ir_d = imem.imem_rdata;
              skid_pc_d = fetch_pc_q;
              state_d   = HOLD;
            end
          end
        end
        HOLD: begin
          if (slot_free) begin
            ir_d    = skid_ir_q;
            pc_d    = skid_pc_q;
            valid_d = 1'b1;
            state_d = FETCH;
          end
        end
        DROP: begin
          if (imem.imem_rvalid) state_d = FETCH;
        end
        default: state_d = FETCH;
      endcase
    end
  end

  // State registers with asynchronous active-low reset; any request that was
  // in flight at reset is simply forgotten.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= FETCH;
      fetch_pc_q <= RESET_PC & 32'hFFFF_FFFC;
      ir_q       <= NOP_IR;
      pc_q       <= 32'h0;
      valid_q    <= 1'b0;
      skid_ir_q  <= NOP_IR;
      skid_pc_q  <= 32'h0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      ir_q       <= ir_d;
      pc_q       <= pc_d;
      valid_q    <= valid_d;
      skid_ir_q  <= skid_ir_d;
      skid_pc_q  <= skid_pc_d;
    end
  end

endmodule
